axis_stream_checker: RTL and testbench

Parametrised AXI4-Stream sink scoreboard for the AES testbenches. Expected beats (data + last) are loaded into an internal FIFO through a simple write port; each accepted stream beat is compared against the FIFO head, using `tstrb` to select which byte lanes are compared. Mismatches are counted and the first one is captured, without halting simulation. An optional pseudo-random backpressure generator exercises `tready` stalls on the DUT master side.

---
 rtl/axis_stream_checker.sv | 182 ++++++++++++++++++
 tb/tb_axis_stream_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI4-Stream sink scoreboard.
// Expected beats {last, data} are queued through a simple write port. Each
// accepted stream beat is compared with the queue head, and tstrb selects
// which byte lanes take part in the comparison. Mismatches are counted, and
// the first mismatch is captured. Simulation is never halted.
// Optional feature macro: AXIS_CHECKER_BACKPRESSURE_EN gates tready with a
// 16-bit LFSR (seed 16'hACE1) to produce deterministic pseudo-random stalls.
module axis_stream_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_SIZE            = 2048
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                exp_wr_en,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     exp_wr_data,
  input  logic                                exp_wr_last,
  output logic                                exp_full,
  output logic                                exp_empty,
  output logic                                s00_axis_tready,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                err,
  output logic                                ovf,
  output logic [15:0]                         err_count,
  output logic [31:0]                         beat_count,
  output logic [15:0]                         pkt_count,
  output logic [31:0]                         err_index,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     err_got,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     err_exp
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int NB = W / 8;
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int PW = AW + 1;

  // Queue storage holds {last, data}. It has no reset because the pointers
  // alone define which entries are valid.
  logic [W:0]    fifo_mem [FIFO_SIZE];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   err_count_q, err_count_d;
  logic [31:0]   beat_count_q, beat_count_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic [31:0]   err_index_q, err_index_d;
  logic [W-1:0]  err_got_q, err_got_d;
  logic [W-1:0]  err_exp_q, err_exp_d;

  logic [W:0]    head;
  logic [W-1:0]  head_data;
  logic          head_last;
  logic          bp_gate;
  logic          push;
  logic          hs;
  logic          lane_mismatch;
  logic          beat_mismatch;

  // The pointer MSB differs when the queue has wrapped, which separates full from empty.
  assign exp_empty = (wr_ptr_q == rd_ptr_q);
  assign exp_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_data = head[W-1:0];
  assign head_last = head[W];

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR with taps 16,14,13,11, shifted right. It advances every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // LFSR state register. Reset loads the fixed seed, so the stall pattern is repeatable.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) lfsr_q <= 16'hACE1;
    else                   lfsr_q <= lfsr_d;
  end

  assign bp_gate = lfsr_q[0];
`else
  assign bp_gate = 1'b1;
`endif

  // Ready depends only on registered state. It has no path from tvalid, tdata or tlast.
  assign s00_axis_tready = !exp_empty && bp_gate;

  assign push = exp_wr_en && !exp_full;
  assign hs   = s00_axis_tvalid && s00_axis_tready;

  // Per-lane data compare. A lane takes part only when its tstrb bit is set.
  always_comb begin
    lane_mismatch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (s00_axis_tstrb[i] && (s00_axis_tdata[8*i +: 8] != head_data[8*i +: 8]))
        lane_mismatch = 1'b1;
    end
  end

  assign beat_mismatch = hs && (lane_mismatch || (s00_axis_tlast != head_last));

  // Next-state logic for the pointers, the sticky flags, the counters and the first-error capture.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    err_count_d  = err_count_q;
    beat_count_d = beat_count_q;
    pkt_count_d  = pkt_count_q;
    err_index_d  = err_index_q;
    err_got_d    = err_got_q;
    err_exp_d    = err_exp_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (exp_wr_en && exp_full) ovf_d = 1'b1;

    if (hs) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      beat_count_d = beat_count_q + 32'd1;
      if (s00_axis_tlast) pkt_count_d = pkt_count_q + 16'd1;
    end

    if (beat_mismatch) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (!err_q) begin
        err_d       = 1'b1;
        err_index_d = beat_count_q;
        err_got_d   = s00_axis_tdata;
        err_exp_d   = head_data;
      end
    end
  end

  // Queue write port. Pushes that arrive while the queue is full never reach this point.
  always_ff @(posedge s00_axis_aclk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {exp_wr_last, exp_wr_data};
  end

  // State registers. The asynchronous reset clears everything, including a beat in flight.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      err_count_q  <= '0;
      beat_count_q <= '0;
      pkt_count_q  <= '0;
      err_index_q  <= '0;
      err_got_q    <= '0;
      err_exp_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      err_count_q  <= err_count_d;
      beat_count_q <= beat_count_d;
      pkt_count_q  <= pkt_count_d;
      err_index_q  <= err_index_d;
      err_got_q    <= err_got_d;
      err_exp_q    <= err_exp_d;
    end
  end

  assign err        = err_q;
  assign ovf        = ovf_q;
  assign err_count  = err_count_q;
  assign beat_count = beat_count_q;
  assign pkt_count  = pkt_count_q;
  assign err_index  = err_index_q;
  assign err_got    = err_got_q;
  assign err_exp    = err_exp_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Testbench for axis_stream_checker. It uses a 4-entry queue and directed vectors.
// When AXIS_CHECKER_BACKPRESSURE_EN is defined, the expected tready pattern
// comes from a reference LFSR model kept in this bench.
module tb_axis_stream_checker;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          expWrEn = 1'b0;
  logic [W-1:0]  expWrData = '0;
  logic          expWrLast = 1'b0;
  logic          expFull, expEmpty, tready;
  logic          tvalid = 1'b0;
  logic [W-1:0]  tdata = '0;
  logic [3:0]    tstrb = '0;
  logic          tlast = 1'b0;
  logic          err, ovf;
  logic [15:0]   errCount, pktCount;
  logic [31:0]   beatCount, errIndex;
  logic [W-1:0]  errGot, errExp;

  int checkCount = 0;
  int failCount  = 0;

  axis_stream_checker #(.C_S_AXIS_TDATA_WIDTH(W), .FIFO_SIZE(DEPTH)) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(rstN),
    .exp_wr_en(expWrEn),
    .exp_wr_data(expWrData),
    .exp_wr_last(expWrLast),
    .exp_full(expFull),
    .exp_empty(expEmpty),
    .s00_axis_tready(tready),
    .s00_axis_tvalid(tvalid),
    .s00_axis_tdata(tdata),
    .s00_axis_tstrb(tstrb),
    .s00_axis_tlast(tlast),
    .err(err),
    .ovf(ovf),
    .err_count(errCount),
    .beat_count(beatCount),
    .pkt_count(pktCount),
    .err_index(errIndex),
    .err_got(errGot),
    .err_exp(errExp)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  logic bpModel;
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsrModel;
  // Reference LFSR: seed 16'hACE1, taps 16,14,13,11, advancing on every clock edge outside reset.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) lfsrModel <= 16'hACE1;
    else       lfsrModel <= {lfsrModel[0] ^ lfsrModel[2] ^ lfsrModel[3] ^ lfsrModel[5], lfsrModel[15:1]};
  end
  assign bpModel = lfsrModel[0];
`else
  assign bpModel = 1'b1;
`endif

  // Watchdog that stops a hung run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checkCount++;
    if (got !== expv) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic wrEn, input logic [W-1:0] wrData, input logic wrLast,
                               input logic tV, input logic [W-1:0] tD, input logic [3:0] tS,
                               input logic tL);
    expWrEn   = wrEn;
    expWrData = wrData;
    expWrLast = wrLast;
    tvalid    = tV;
    tdata     = tD;
    tstrb     = tS;
    tlast     = tL;
  endtask

  task automatic applyReset();
    applyStimulus(0, '0, 0, 0, '0, '0, 0);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitReady();
    int n = 0;
    while (!tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) checkOutput("ready_timeout", 64'(tready), 64'd1);
  endtask

  task automatic pushBeat(input logic [W-1:0] d, input logic l);
    applyStimulus(1, d, l, 0, '0, '0, 0);
    @(negedge clk);
    applyStimulus(0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic sendBeat(input logic [W-1:0] d, input logic [3:0] s, input logic l);
    applyStimulus(0, '0, 0, 1, d, s, l);
    waitReady();
    @(negedge clk);
    applyStimulus(0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic pushPop(input logic [W-1:0] pushD, input logic [W-1:0] popD);
    applyStimulus(0, '0, 0, 1, popD, 4'hF, 0);
    waitReady();
    applyStimulus(1, pushD, 0, 1, popD, 4'hF, 0);
    @(negedge clk);
    applyStimulus(0, '0, 0, 0, '0, '0, 0);
  endtask

  // Streams 'total' beats with tvalid held high. The bench tracks occupancy and stalls itself.
  task automatic streamBeats(input int total, input bit corrupt);
    int occ = 0, pushIdx = 0, popIdx = 0, cycles = 0;
    logic expReady, doPush, doPop;
    while (popIdx < total && cycles < total * 4 + 100) begin
      expReady = (occ != 0) && bpModel;
      checkOutput("stream_tready", 64'(tready), 64'(expReady));
      doPush = (occ < DEPTH) && (pushIdx < total);
      doPop  = expReady;
      applyStimulus(doPush, 32'(pushIdx), (pushIdx % 16) == 15, 1,
                    corrupt ? (32'(popIdx) ^ 32'h1) : 32'(popIdx), 4'hF, (popIdx % 16) == 15);
      @(negedge clk);
      cycles++;
      if (doPop)  popIdx++;
      if (doPush) pushIdx++;
      occ = occ + (doPush ? 1 : 0) - (doPop ? 1 : 0);
    end
    applyStimulus(0, '0, 0, 0, '0, '0, 0);
    checkOutput("stream_done", 64'(popIdx), 64'(total));
  endtask

  initial begin
    applyStimulus(0, '0, 0, 0, '0, '0, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst_empty", 64'(expEmpty), 64'd1);
    checkOutput("rst_full", 64'(expFull), 64'd0);
    checkOutput("rst_tready", 64'(tready), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_beats", 64'(beatCount), 64'd0);

    $display("[TB] clean 4-beat packet");
    for (int i = 1; i <= 4; i++) pushBeat(32'(i), i == 4);
    checkOutput("clean_full", 64'(expFull), 64'd1);
    for (int i = 1; i <= 4; i++) sendBeat(32'(i), 4'hF, i == 4);
    checkOutput("clean_err", 64'(err), 64'd0);
    checkOutput("clean_beats", 64'(beatCount), 64'd4);
    checkOutput("clean_pkts", 64'(pktCount), 64'd1);
    checkOutput("clean_empty", 64'(expEmpty), 64'd1);
    checkOutput("clean_tready", 64'(tready), 64'd0);

    $display("[TB] strobed mismatch");
    applyReset();
    pushBeat(32'hAABBCCDD, 0);
    sendBeat(32'hAABBCC00, 4'b1110, 0);
    checkOutput("strb_masked_err", 64'(err), 64'd0);
    pushBeat(32'hAABBCCDD, 0);
    sendBeat(32'hAABBCC00, 4'b1111, 0);
    checkOutput("strb_err", 64'(err), 64'd1);
    checkOutput("strb_err_count", 64'(errCount), 64'd1);
    checkOutput("strb_err_index", 64'(errIndex), 64'd1);
    checkOutput("strb_err_got", 64'(errGot), 64'hAABBCC00);
    checkOutput("strb_err_exp", 64'(errExp), 64'hAABBCCDD);
    pushBeat(32'h12345678, 0);
    sendBeat(32'h00000000, 4'b0000, 0);
    checkOutput("strb_zero_count", 64'(errCount), 64'd1);
    pushBeat(32'h00000000, 1);
    sendBeat(32'hFFFFFFFF, 4'b0000, 0);
    checkOutput("strb_zero_last_count", 64'(errCount), 64'd2);
    checkOutput("strb_index_hold", 64'(errIndex), 64'd1);

    $display("[TB] last mismatch and saturation");
    applyReset();
    pushBeat(32'h11, 1);
    sendBeat(32'h11, 4'hF, 0);
    checkOutput("last_err", 64'(err), 64'd1);
    checkOutput("last_err_index", 64'(errIndex), 64'd0);
    streamBeats(65538, 1'b1);
    checkOutput("sat_err_count", 64'(errCount), 64'hFFFF);
    checkOutput("sat_err_index", 64'(errIndex), 64'd0);
    checkOutput("sat_err_got", 64'(errGot), 64'h11);
    checkOutput("sat_err_exp", 64'(errExp), 64'h11);
    checkOutput("sat_beats", 64'(beatCount), 64'd65539);
    checkOutput("sat_pkts", 64'(pktCount), 64'd4096);

    $display("[TB] full, overflow, simultaneous push/pop");
    applyReset();
    for (int i = 0; i < 4; i++) pushBeat(32'hA0 + 32'(i), 0);
    checkOutput("ovf_full", 64'(expFull), 64'd1);
    checkOutput("ovf_before", 64'(ovf), 64'd0);
    pushBeat(32'hA4, 0);
    checkOutput("ovf_set", 64'(ovf), 64'd1);
    checkOutput("ovf_still_full", 64'(expFull), 64'd1);
    pushPop(32'hB9, 32'hA0);
    checkOutput("pp_full_drop", 64'(expFull), 64'd0);
    pushPop(32'hB0, 32'hA1);
    checkOutput("pp_same_full", 64'(expFull), 64'd0);
    checkOutput("pp_same_empty", 64'(expEmpty), 64'd0);
    pushBeat(32'hB1, 0);
    checkOutput("pp_refull", 64'(expFull), 64'd1);
    sendBeat(32'hA2, 4'hF, 0);
    sendBeat(32'hA3, 4'hF, 0);
    sendBeat(32'hB0, 4'hF, 0);
    sendBeat(32'hB1, 4'hF, 0);
    checkOutput("pp_err", 64'(err), 64'd0);
    checkOutput("pp_empty", 64'(expEmpty), 64'd1);
    checkOutput("pp_beats", 64'(beatCount), 64'd6);

    $display("[TB] reset mid-packet");
    applyReset();
    for (int i = 0; i < 4; i++) pushBeat(32'hC0 + 32'(i), i == 3);
    pushBeat(32'hC4, 0);
    sendBeat(32'hC0, 4'hF, 0);
    sendBeat(32'hEE, 4'hF, 0);
    checkOutput("mid_err_before", 64'(err), 64'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid_empty", 64'(expEmpty), 64'd1);
    checkOutput("mid_full", 64'(expFull), 64'd0);
    checkOutput("mid_tready", 64'(tready), 64'd0);
    checkOutput("mid_err", 64'(err), 64'd0);
    checkOutput("mid_ovf", 64'(ovf), 64'd0);
    checkOutput("mid_err_count", 64'(errCount), 64'd0);
    checkOutput("mid_beats", 64'(beatCount), 64'd0);
    checkOutput("mid_pkts", 64'(pktCount), 64'd0);
    checkOutput("mid_err_index", 64'(errIndex), 64'd0);
    checkOutput("mid_err_got", 64'(errGot), 64'd0);
    checkOutput("mid_err_exp", 64'(errExp), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_tready", 64'(tready), 64'd0);
    pushBeat(32'hD0, 0);
    checkOutput("post_push_empty", 64'(expEmpty), 64'd0);
    checkOutput("post_push_tready", 64'(tready), 64'(bpModel));

    $display("[TB] 256-beat stream");
    applyReset();
    streamBeats(256, 1'b0);
    checkOutput("stream_err", 64'(err), 64'd0);
    checkOutput("stream_err_count", 64'(errCount), 64'd0);
    checkOutput("stream_beats", 64'(beatCount), 64'd256);
    checkOutput("stream_pkts", 64'(pktCount), 64'd16);
    checkOutput("stream_empty", 64'(expEmpty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
